chacha_session_ctrl: RTL and testbench

Byte-serial command sequencer sitting between the tile's 8-bit host pins and the ChaCha encryption core. It accepts load commands for key, nonce and block counter, holds them in a register file driven onto the core's configuration inputs, then issues block-start pulses and forwards 64 keystream bytes per block. It increments the block counter after every block and refuses to reuse a counter after 32-bit wrap.

---
 rtl/chacha_pkg.sv | 42 ++++
 rtl/chacha_session_ctrl_if.sv | 26 ++
 rtl/chacha_session_ctrl.sv | 148 ++++++++++++++
 tb/tb_chacha_session_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chacha_pkg.sv
// Shared opcodes, state encoding and field sizes for the ChaCha session
// controller and its host-side byte streams.
package chacha_pkg;

    typedef logic [7:0] byte_t;

    localparam byte_t OP_LOAD_KEY   = 8'h01;
    localparam byte_t OP_LOAD_NONCE = 8'h02;
    localparam byte_t OP_LOAD_CTR   = 8'h03;
    localparam byte_t OP_RUN        = 8'h04;
    localparam byte_t OP_CLR        = 8'h05;

    localparam int KEY_BYTES   = 32;
    localparam int NONCE_BYTES = 12;
    localparam int CTR_BYTES   = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN_START,
        S_RUN_WAIT,
        S_RUN_STREAM
    } state_t;

    // Destination of the payload bytes that follow an opcode.
    typedef enum logic [1:0] {
        F_KEY,
        F_NONCE,
        F_CTR,
        F_RUN
    } field_t;

    function automatic logic [5:0] field_last(input field_t f);
        case (f)
            F_KEY:   return 6'(KEY_BYTES - 1);
            F_NONCE: return 6'(NONCE_BYTES - 1);
            F_CTR:   return 6'(CTR_BYTES - 1);
            default: return 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/chacha_session_ctrl_if.sv
// Byte streams around the session controller: host commands in, keystream
// from the core in, keystream to downstream out.
interface chacha_session_ctrl_if;
    import chacha_pkg::*;

    byte_t in_data;
    logic  in_valid;
    logic  in_ready;
    byte_t ks_data;
    logic  ks_valid;
    logic  ks_ready;
    byte_t out_data;
    logic  out_valid;
    logic  out_ready;

    modport master (
        output in_data, in_valid, ks_data, ks_valid, out_ready,
        input  in_ready, ks_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, ks_data, ks_valid, out_ready,
        output in_ready, ks_ready, out_data, out_valid
    );

endinterface

// File: rtl/chacha_session_ctrl.sv
// Byte-serial command sequencer: loads key/nonce/counter, starts ChaCha
// blocks and forwards 64 keystream bytes per block to the host side.
module chacha_session_ctrl
    import chacha_pkg::*;
#(
    parameter int BLOCK_BYTES = 64,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    chacha_session_ctrl_if.slave  bus,
    output logic [255:0]          key,
    output logic [95:0]           nonce,
    output logic [31:0]           counter,
    output logic                  core_start,
    output logic                  busy,
    output logic                  err
);

    localparam int          WD_W    = $clog2(WDOG_CYCLES) + 1;
    localparam logic [5:0]  LAST_KS = 6'(BLOCK_BYTES - 1);

    state_t      state;
    field_t      field;
    logic [5:0]  byte_idx;
    logic [8:0]  blocks_left;
    logic [WD_W-1:0] wdog;

    logic streaming;
    logic in_fire;
    logic ks_fire;

    assign streaming     = (state == S_RUN_STREAM);
    assign bus.in_ready  = (state == S_IDLE) || (state == S_LOAD);
    assign busy          = (state == S_RUN_START) || (state == S_RUN_WAIT) || streaming;
    assign bus.ks_ready  = streaming & bus.out_ready;
    assign bus.out_valid = streaming & bus.ks_valid;
    assign bus.out_data  = bus.ks_data;
    assign in_fire       = bus.in_valid & bus.in_ready;
    assign ks_fire       = bus.ks_valid & bus.ks_ready;

    // NOTE: every register here, including the 256-bit key, is a flop with
    // a defined reset value; nothing is a RAM, so resetting it all is cheap
    // and keeps the core configuration deterministic after reset.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // branch below sees the pre-edge values of counter, byte_idx, etc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            field       <= F_KEY;
            byte_idx    <= '0;
            blocks_left <= '0;
            wdog        <= '0;
            key         <= '0;
            nonce       <= '0;
            counter     <= '0;
            core_start  <= 1'b0;
            err         <= 1'b0;
        end else begin
            core_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_fire) begin
                        byte_idx <= '0;
                        case (bus.in_data)
                            OP_LOAD_KEY:   begin field <= F_KEY;   state <= S_LOAD; end
                            OP_LOAD_NONCE: begin field <= F_NONCE; state <= S_LOAD; end
                            OP_LOAD_CTR:   begin field <= F_CTR;   state <= S_LOAD; end
                            OP_RUN:        begin field <= F_RUN;   state <= S_LOAD; end
                            OP_CLR:        err <= 1'b0;
                            default:       err <= 1'b1;
                        endcase
                    end
                end

                S_LOAD: begin
                    if (in_fire) begin
                        case (field)
                            F_KEY:
                                for (int i = 0; i < KEY_BYTES; i++)
                                    if (byte_idx == 6'(i)) key[8*i +: 8] <= bus.in_data;
                            F_NONCE:
                                for (int i = 0; i < NONCE_BYTES; i++)
                                    if (byte_idx == 6'(i)) nonce[8*i +: 8] <= bus.in_data;
                            F_CTR:
                                for (int i = 0; i < CTR_BYTES; i++)
                                    if (byte_idx == 6'(i)) counter[8*i +: 8] <= bus.in_data;
                            default:
                                blocks_left <= (bus.in_data == 8'd0) ? 9'd256 : {1'b0, bus.in_data};
                        endcase
                        if (byte_idx == field_last(field)) begin
                            byte_idx <= '0;
                            if (field == F_RUN) begin
                                state      <= S_RUN_START;
                                core_start <= 1'b1;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else begin
                            byte_idx <= byte_idx + 6'd1;
                        end
                    end
                end

                S_RUN_START: begin
                    wdog  <= '0;
                    state <= S_RUN_WAIT;
                end

                S_RUN_WAIT: begin
                    if (bus.ks_valid) begin
                        state <= S_RUN_STREAM;
                    end else if (wdog == WD_W'(WDOG_CYCLES - 1)) begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        wdog <= wdog + WD_W'(1);
                    end
                end

                S_RUN_STREAM: begin
                    if (ks_fire) begin
                        if (byte_idx == LAST_KS) begin
                            byte_idx    <= '0;
                            counter     <= counter + 32'd1;
                            blocks_left <= blocks_left - 9'd1;
                            // A wrapped counter would reuse keystream: stop the run.
                            if (counter == 32'hFFFF_FFFF) begin
                                err   <= 1'b1;
                                state <= S_IDLE;
                            end else if (blocks_left == 9'd1) begin
                                state <= S_IDLE;
                            end else begin
                                state      <= S_RUN_START;
                                core_start <= 1'b1;
                            end
                        end else begin
                            byte_idx <= byte_idx + 6'd1;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chacha_session_ctrl.sv
// Scoreboarded bench for chacha_session_ctrl: a behavioural core model feeds
// random keystream, a monitor checks every forwarded byte and block counter.
module tb_chacha_session_ctrl;
    import chacha_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    chacha_session_ctrl_if bus ();
    logic [255:0] key;
    logic [95:0]  nonce;
    logic [31:0]  counter;
    logic         core_start, busy, err;

    chacha_session_ctrl dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .key(key), .nonce(nonce), .counter(counter),
        .core_start(core_start), .busy(busy), .err(err)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  m_key [KEY_BYTES];
    logic [7:0]  m_nonce [NONCE_BYTES];
    logic [31:0] m_ctr;
    logic        m_err;

    logic [7:0]  exp_q[$];
    logic [7:0]  ks_q[$];
    logic [31:0] ctr_q[$];
    int          n_starts;
    int          or_mode;
    bit          ks_dead;
    bit          ks_gaps;
    int          last_stalls;
    int          last_cycles;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    function automatic logic [255:0] key_vec();
        logic [255:0] v;
        for (int i = 0; i < KEY_BYTES; i++) v[8*i +: 8] = m_key[i];
        return v;
    endfunction

    function automatic logic [95:0] nonce_vec();
        logic [95:0] v;
        for (int i = 0; i < NONCE_BYTES; i++) v[8*i +: 8] = m_nonce[i];
        return v;
    endfunction

    // Core model: each start pulse yields one block of fresh random keystream.
    always @(negedge clk) begin
        if (rst_n && core_start) begin
            n_starts++;
            if (ctr_q.size() == 0) timeout("unexpected_core_start");
            else check("start_counter", counter, ctr_q.pop_front());
            if (!ks_dead) begin
                for (int i = 0; i < 64; i++) begin
                    logic [7:0] b;
                    b = 8'($urandom);
                    ks_q.push_back(b);
                    exp_q.push_back(b);
                end
            end
        end
    end

    // Core output driver and downstream ready pattern.
    always begin
        bit xfer;
        @(negedge clk);
        case (or_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ~bus.out_ready;
            default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
        if (ks_q.size() > 0 && (!ks_gaps || $urandom_range(0, 3) != 0)) begin
            bus.ks_valid = 1'b1;
            bus.ks_data  = ks_q[0];
        end else begin
            bus.ks_valid = 1'b0;
            bus.ks_data  = 8'($urandom);
        end
        #1 xfer = bus.ks_valid && bus.ks_ready;
        @(posedge clk);
        if (xfer && ks_q.size() > 0) void'(ks_q.pop_front());
    end

    // Output monitor: every downstream transfer must match the next expected byte.
    always begin
        @(negedge clk);
        #2;
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) timeout("unexpected_out_byte");
            else check("out_data", bus.out_data, exp_q.pop_front());
        end
    end

    task automatic send_byte(input logic [7:0] b, output int stalls);
        stalls = 0;
        @(negedge clk);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && stalls < 10000) begin
            @(negedge clk);
            stalls++;
        end
        if (stalls >= 10000) timeout("in_ready_wait");
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        last_cycles = 0;
        @(negedge clk);
        while (busy && last_cycles < 40000) begin
            @(negedge clk);
            last_cycles++;
        end
        if (last_cycles >= 40000) timeout("run_done_wait");
    endtask

    task automatic do_cmd(input logic [7:0] op, input logic [7:0] pl[$], input bit wait_done);
        int st;
        int blocks;
        int exp_starts;
        last_stalls = 0;
        n_starts    = 0;
        exp_starts  = 0;
        send_byte(op, st);
        last_stalls += st;
        foreach (pl[i]) begin
            send_byte(pl[i], st);
            last_stalls += st;
        end
        case (op)
            OP_LOAD_KEY:   foreach (pl[i]) m_key[i] = pl[i];
            OP_LOAD_NONCE: foreach (pl[i]) m_nonce[i] = pl[i];
            OP_LOAD_CTR:   m_ctr = {pl[3], pl[2], pl[1], pl[0]};
            OP_CLR:        m_err = 1'b0;
            OP_RUN: begin
                blocks = (pl[0] == 8'd0) ? 256 : int'(pl[0]);
                if (ks_dead) begin
                    ctr_q.push_back(m_ctr);
                    exp_starts = 1;
                    m_err = 1'b1;
                end else begin
                    for (int b = 0; b < blocks; b++) begin
                        ctr_q.push_back(m_ctr);
                        exp_starts++;
                        m_ctr = m_ctr + 32'd1;
                        if (m_ctr == 32'd0) begin
                            m_err = 1'b1;
                            break;
                        end
                    end
                end
                @(negedge clk);
                check("start_latency", core_start, 1'b1);
                if (wait_done) begin
                    wait_idle();
                    check("start_count", n_starts, exp_starts);
                    check("bytes_pending", exp_q.size(), 0);
                end
            end
            default: m_err = 1'b1;
        endcase
    endtask

    task automatic check_regs(input string tag);
        @(negedge clk);
        check({tag, "_key"}, key, key_vec());
        check({tag, "_nonce"}, nonce, nonce_vec());
        check({tag, "_counter"}, counter, m_ctr);
        check({tag, "_err"}, err, m_err);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_in_ready"}, bus.in_ready, 1'b1);
    endtask

    task automatic model_reset();
        foreach (m_key[i]) m_key[i] = 8'h00;
        foreach (m_nonce[i]) m_nonce[i] = 8'h00;
        m_ctr = '0;
        m_err = 1'b0;
        exp_q.delete();
        ks_q.delete();
        ctr_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [7:0] pl[$];
        logic [7:0] op;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.ks_valid  = 1'b0;
        bus.ks_data   = 8'h00;
        bus.out_ready = 1'b1;
        or_mode = 0;
        ks_dead = 1'b0;
        ks_gaps = 1'b0;
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_core_start", core_start, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_ks_ready", bus.ks_ready, 1'b0);
        rst_n = 1'b1;
        check_regs("reset");

        // Key bytes 0x00..0x1F with no host stalls.
        pl.delete();
        for (int i = 0; i < 32; i++) pl.push_back(8'(i));
        do_cmd(OP_LOAD_KEY, pl, 1'b1);
        check("key_in_ready_stalls", last_stalls, 0);
        check_regs("load_key");

        // Two blocks from counter 7.
        pl = '{8'h07, 8'h00, 8'h00, 8'h00};
        do_cmd(OP_LOAD_CTR, pl, 1'b1);
        pl = '{8'h02};
        do_cmd(OP_RUN, pl, 1'b1);
        check_regs("run2");

        // Downstream ready toggling every other cycle.
        or_mode = 1;
        pl = '{8'h01};
        do_cmd(OP_RUN, pl, 1'b1);
        check_regs("toggle_ready");

        // Counter wrap ends the run after one block.
        or_mode = 0;
        pl = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        do_cmd(OP_LOAD_CTR, pl, 1'b1);
        pl = '{8'h03};
        do_cmd(OP_RUN, pl, 1'b1);
        check_regs("wrap");
        pl.delete();
        do_cmd(OP_CLR, pl, 1'b1);
        check_regs("clr_after_wrap");

        // Unknown opcode, then a normal nonce load.
        do_cmd(8'h7E, pl, 1'b1);
        check_regs("bad_opcode");
        for (int i = 0; i < NONCE_BYTES; i++) pl.push_back(8'($urandom));
        do_cmd(OP_LOAD_NONCE, pl, 1'b1);
        check_regs("nonce_after_bad");
        pl.delete();
        do_cmd(OP_CLR, pl, 1'b1);

        // N=0 runs 256 blocks.
        pl = '{8'h10, 8'h20, 8'h30, 8'h40};
        do_cmd(OP_LOAD_CTR, pl, 1'b1);
        pl = '{8'h00};
        do_cmd(OP_RUN, pl, 1'b1);
        check_regs("run256");

        // Random command mix with random ready and keystream gaps.
        or_mode = 2;
        ks_gaps = 1'b1;
        for (int it = 0; it < 10; it++) begin
            pl.delete();
            case ($urandom_range(0, 5))
                0: begin op = OP_LOAD_KEY;   for (int i = 0; i < KEY_BYTES; i++)   pl.push_back(8'($urandom)); end
                1: begin op = OP_LOAD_NONCE; for (int i = 0; i < NONCE_BYTES; i++) pl.push_back(8'($urandom)); end
                2: begin op = OP_LOAD_CTR;   for (int i = 0; i < CTR_BYTES; i++)   pl.push_back(8'($urandom)); end
                3: begin op = OP_RUN;        pl.push_back(8'($urandom_range(1, 3))); end
                4: op = OP_CLR;
                default: op = 8'($urandom_range(6, 255));
            endcase
            do_cmd(op, pl, 1'b1);
            check_regs("random");
        end
        ks_gaps = 1'b0;
        or_mode = 0;

        // Core never answers: watchdog abort.
        ks_dead = 1'b1;
        pl = '{8'h01};
        do_cmd(OP_RUN, pl, 1'b1);
        check("wdog_window", (last_cycles >= 4090) && (last_cycles <= 4110), 1'b1);
        check_regs("watchdog");
        ks_dead = 1'b0;
        pl.delete();
        do_cmd(OP_CLR, pl, 1'b1);

        // Asynchronous reset in the middle of a block.
        or_mode = 1;
        pl = '{8'h01};
        do_cmd(OP_RUN, pl, 1'b0);
        repeat (40) @(negedge clk);
        check("pre_reset_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_key", key, '0);
        check("mid_rst_counter", counter, '0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_err", err, 1'b0);
        check("mid_rst_core_start", core_start, 1'b0);
        check("mid_rst_out_valid", bus.out_valid, 1'b0);
        check("mid_rst_ks_ready", bus.ks_ready, 1'b0);
        check("mid_rst_in_ready", bus.in_ready, 1'b1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        or_mode = 0;
        check_regs("after_mid_reset");

        check("final_exp_q", exp_q.size(), 0);
        check("final_ctr_q", ctr_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
